clk_div_6: RTL and testbench
============================

// Module: clk_div_6
//
// PURPOSE
//   Synchronous clock divider; default ratio divides i_clk by 6.
//   Produces a registered divided clock and a one-cycle wrap tick.
//   Sits in the clocking utilities layer and feeds slow-rate logic.
//   o_div_clk is a fabric signal. It is not a clock-tree source.
//   Its output edges are aligned to rising edges of i_clk.
//
// PARAMETERS
//   DIV_RATIO  6                         division ratio N; legal range N >= 2
//   CNT_W      $clog2(DIV_RATIO)         phase counter width (localparam, not overridable)
//   LOW_CYC    DIV_RATIO/2 (floor)       i_clk cycles low per output period (localparam)
//
// PORTS
//   i_clk      in   1  single clock; all logic on rising edge
//   i_reset    in   1  one clock; reset is synchronous and active-high
//   i_en       in   1  count enable; 1 = run, 0 = hold phase
//   o_div_clk  out  1  divided clock; period N cycles; low LOW_CYC, high N-LOW_CYC
//   o_tick     out  1  1-cycle pulse while phase counter == N-1
//
// BEHAVIOUR
//   - Internal phase counter cnt[CNT_W-1:0]; all outputs registered.
//   - Reset (i_reset=1 at a rising edge):
//       cnt=0, o_div_clk=0, o_tick=0.
//       Reset has priority over i_en.
//       Reset mid-period restarts the phase from 0 at the next edge.
//   - Run (i_reset=0, i_en=1), evaluated each rising edge:
//       cnt_nxt = (cnt == N-1) ? 0 : cnt + 1
//       cnt <= cnt_nxt
//       o_div_clk <= (cnt_nxt >= LOW_CYC)
//       o_tick <= (cnt_nxt == N-1)
//     Invariant: o_div_clk == (cnt >= LOW_CYC) and o_tick == (cnt == N-1).
//   - Hold (i_en=0):
//       cnt and o_div_clk keep their values; o_tick forced to 0.
//       On resume, the phase continues with no lost or extra count.
//   - Default N=6 (LOW_CYC=3):
//       cnt sequence 0,1,2,3,4,5,0,...
//       o_div_clk is low for cnt 0..2 and high for cnt 3..5 (50% duty).
//       First rising edge of o_div_clk: 3rd i_clk edge after reset release.
//       That edge occurs with i_en=1 continuously.
//   - Odd N: high phase is one cycle longer than low phase.
//     Example N=5: low 2, high 3.
//   - N=2: o_div_clk toggles every cycle (i_clk/2); o_tick is high when cnt=1.
//   - Wrap-around: cnt never exceeds N-1.
//     This holds even when N is not a power of two; no illegal states.
//   - No latency beyond the register stage.
//   - No combinational path from inputs to outputs.
//
// TESTING
//   1. N=6, i_clk 20 ns period, i_reset=1 for 2 edges, then 0; i_en=1:
//      -> o_div_clk=0 during reset and period = 120 ns, high 60 ns, low 60 ns.
//   2. Same bench: o_tick is high 1 cycle every 6 cycles.
//      -> It coincides with the last high cycle of o_div_clk (cnt=5).
//   3. Assert i_reset for 1 edge at cnt=4 (o_div_clk=1):
//      -> next edge: o_div_clk=0, o_tick=0; then 3 low cycles and 3 high cycles resume.
//   4. Drop i_en for 5 cycles at cnt=2:
//      -> o_div_clk holds 0 and o_tick stays 0.
//      -> After re-enable, o_div_clk rises on the 1st edge (cnt 2->3).
//   5. DIV_RATIO=5:
//      -> o_div_clk low 2 / high 3, period 100 ns; o_tick period 5 cycles.
//   6. DIV_RATIO=2:
//      -> o_div_clk toggles every edge; o_tick=1 exactly when o_div_clk=1.

Source files
------------

// File: rtl/clk_div_6.sv
// Synchronous divide-by-N fabric clock with one-cycle wrap tick.
// Outputs are registered; i_en freezes the phase without losing counts.
module clk_div_6 #(
  parameter int DIV_RATIO = 6
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_div_clk,
  output logic o_tick
);

  localparam int CNT_W   = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam int LOW_CYC = DIV_RATIO / 2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_RATIO - 1);
  localparam logic [CNT_W-1:0] LOW  = CNT_W'(LOW_CYC);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             div_q;
  logic             div_d;
  logic             tick_q;
  logic             tick_d;

  // Explicit wrap keeps non-power-of-two ratios inside 0..N-1.
  always_comb begin
    cnt_inc = (cnt_q == LAST) ? '0 : cnt_q + ONE;
    cnt_d   = cnt_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    if (i_en) begin
      cnt_d  = cnt_inc;
      div_d  = (cnt_inc >= LOW);
      tick_d = (cnt_inc == LAST);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q  <= '0;
      div_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign o_div_clk = div_q;
  assign o_tick    = tick_q;

endmodule

// File: tb/tb_clk_div_6.sv
// Scoreboard bench for clk_div_6 at ratios 6, 5 and 2.
// Expected outputs come from a count of enabled edges since reset.
module tb_clk_div_6;

  logic clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_en = 1'b0;

  logic div6, tick6, div5, tick5, div2, tick2;

  always #10 clk = ~clk;

  clk_div_6 #(.DIV_RATIO(6)) u_div6 (
    .i_clk(clk), .i_reset(i_reset), .i_en(i_en),
    .o_div_clk(div6), .o_tick(tick6)
  );

  clk_div_6 #(.DIV_RATIO(5)) u_div5 (
    .i_clk(clk), .i_reset(i_reset), .i_en(i_en),
    .o_div_clk(div5), .o_tick(tick5)
  );

  clk_div_6 #(.DIV_RATIO(2)) u_div2 (
    .i_clk(clk), .i_reset(i_reset), .i_en(i_en),
    .o_div_clk(div2), .o_tick(tick2)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [5:0] exp_q[$];

  // k = enabled edges since the last reset; phase for ratio N is k mod N.
  int k = 0;
  bit tk = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic logic [5:0] model(input int kk, input bit adv);
    logic [5:0] e;
    e[5] = ((kk % 6) >= 3);
    e[4] = adv && ((kk % 6) == 5);
    e[3] = ((kk % 5) >= 2);
    e[2] = adv && ((kk % 5) == 4);
    e[1] = ((kk % 2) >= 1);
    e[0] = adv && ((kk % 2) == 1);
    return e;
  endfunction

  task automatic step(input logic rst, input logic en);
    @(negedge clk);
    i_reset = rst;
    i_en    = en;
    if (rst) begin
      k  = 0;
      tk = 1'b0;
    end else if (en) begin
      k  = k + 1;
      tk = 1'b1;
    end else begin
      tk = 1'b0;
    end
    exp_q.push_back(model(k, tk));
  endtask

  // Monitor: compare every DUT output one delta-safe #1 after each edge.
  initial begin
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("div6", div6, e[5]);
        check("tick6", tick6, e[4]);
        check("div5", div5, e[3]);
        check("tick5", tick5, e[2]);
        check("div2", div2, e[1]);
        check("tick2", tick2, e[0]);
      end
    end
  end

  initial begin
    int rnd;
    // Reset held for two edges with enable already high.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    repeat (30) step(1'b0, 1'b1);

    // Mid-period reset with the N=6 phase at 4.
    while ((k % 6) != 4) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (14) step(1'b0, 1'b1);

    // Hold five cycles with the N=6 phase at 2.
    while ((k % 6) != 2) step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1);

    // Reset while holding must still win.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b1);

    for (int i = 0; i < 2000; i++) begin
      rnd = int'($urandom_range(0, 99));
      if (rnd < 3)       step(1'b1, ($urandom_range(0, 1) == 1));
      else if (rnd < 28) step(1'b0, 1'b0);
      else               step(1'b0, 1'b1);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", (exp_q.size() == 0), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
